// File: rtl/controle_pkg.sv
// Shared types and encodings for the multicycle MIPS main control FSM.
package controle_pkg;

    localparam int unsigned OPW       = 6;
    localparam int unsigned OPSEL_W   = 4;
    localparam int unsigned STATE_W   = 4;
    localparam int unsigned SRCB_W    = 2;
    localparam int unsigned PCSRC_W   = 2;

    typedef enum logic [STATE_W-1:0] {
        RESET     = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        MEMADDR   = 4'd3,
        MEMREAD   = 4'd4,
        MEM_WB    = 4'd5,
        MEMWRITE  = 4'd6,
        EXEC_R    = 4'd7,
        R_WB      = 4'd8,
        BRANCH    = 4'd9,
        JUMP      = 4'd10,
        ADDI_EXEC = 4'd11,
        ADDI_WB   = 4'd12,
        BRANCH_NE = 4'd13
    } state_t;

    localparam logic [OPW-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPW-1:0] OP_J     = 6'h02;
    localparam logic [OPW-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPW-1:0] OP_BNE   = 6'h05;
    localparam logic [OPW-1:0] OP_ADDI  = 6'h08;
    localparam logic [OPW-1:0] OP_LW    = 6'h23;
    localparam logic [OPW-1:0] OP_SW    = 6'h2B;

    localparam logic [OPW-1:0] FN_ADD = 6'h20;
    localparam logic [OPW-1:0] FN_SUB = 6'h22;
    localparam logic [OPW-1:0] FN_AND = 6'h24;
    localparam logic [OPW-1:0] FN_OR  = 6'h25;
    localparam logic [OPW-1:0] FN_NOR = 6'h27;
    localparam logic [OPW-1:0] FN_SLT = 6'h2A;

    localparam logic [OPSEL_W-1:0] ULA_AND = 4'b0000;
    localparam logic [OPSEL_W-1:0] ULA_OR  = 4'b0001;
    localparam logic [OPSEL_W-1:0] ULA_ADD = 4'b0010;
    localparam logic [OPSEL_W-1:0] ULA_SUB = 4'b0110;
    localparam logic [OPSEL_W-1:0] ULA_SLT = 4'b0111;
    localparam logic [OPSEL_W-1:0] ULA_NOR = 4'b1100;

    localparam logic [SRCB_W-1:0] SRCB_REG    = 2'b00;
    localparam logic [SRCB_W-1:0] SRCB_FOUR   = 2'b01;
    localparam logic [SRCB_W-1:0] SRCB_IMM    = 2'b10;
    localparam logic [SRCB_W-1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [PCSRC_W-1:0] PCSRC_ULA    = 2'b00;
    localparam logic [PCSRC_W-1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [PCSRC_W-1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic [OPSEL_W-1:0] ula_op;
        logic               pc_write;
        logic               i_or_d;
        logic               mem_read;
        logic               mem_write;
        logic               ir_write;
        logic               reg_dst;
        logic               mem_to_reg;
        logic               reg_write;
        logic               ula_src_a;
        logic [SRCB_W-1:0]  ula_src_b;
        logic [PCSRC_W-1:0] pc_source;
        logic               illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{ula_op: ULA_ADD, default: '0};

endpackage

// File: rtl/controle_multiciclo_ula_controle.sv
// Decodes the R-type funct field into a ULA operation plus a validity flag.
module ula_controle
    import controle_pkg::*;
(
    input  logic [OPW-1:0]     funct,
    output logic [OPSEL_W-1:0] ula_operation,
    output logic               funct_valid
);

    always_comb begin
        ula_operation = ULA_ADD;
        funct_valid   = 1'b1;
        case (funct)
            FN_ADD:  ula_operation = ULA_ADD;
            FN_SUB:  ula_operation = ULA_SUB;
            FN_AND:  ula_operation = ULA_AND;
            FN_OR:   ula_operation = ULA_OR;
            FN_NOR:  ula_operation = ULA_NOR;
            FN_SLT:  ula_operation = ULA_SLT;
            default: funct_valid   = 1'b0;
        endcase
    end

endmodule

// File: rtl/controle_multiciclo.sv
// Main multicycle MIPS control FSM. Define CTRL_BNE_EN to add bne (opcode 0x05).
module controle_multiciclo
    import controle_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [OPW-1:0]     opcode,
    input  logic [OPW-1:0]     funct,
    input  logic               flagz,
    output logic [OPSEL_W-1:0] ULAoperation,
    output logic               pc_write,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               ula_src_a,
    output logic [SRCB_W-1:0]  ula_src_b,
    output logic [PCSRC_W-1:0] pc_source,
    output logic               illegal_instr,
    output logic [STATE_W-1:0] state_dbg
);

    state_t             state, state_nxt;
    ctrl_t              ctrl_q, ctrl_nxt;
    logic               illegal_nxt;
    logic               br_eq_q, br_ne_q;
    logic [OPSEL_W-1:0] fn_op;
    logic               fn_valid;

    ula_controle u_ula_controle (
        .funct         (funct),
        .ula_operation (fn_op),
        .funct_valid   (fn_valid)
    );

    // Next-state: IR is stable from DECODE on, so opcode/funct are sampled there and in EXEC_R.
    always_comb begin
        state_nxt   = FETCH;
        illegal_nxt = 1'b0;
        case (state)
            RESET:   state_nxt = FETCH;
            FETCH:   state_nxt = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_nxt = MEMADDR;
                    OP_RTYPE:     state_nxt = EXEC_R;
                    OP_BEQ:       state_nxt = BRANCH;
`ifdef CTRL_BNE_EN
                    OP_BNE:       state_nxt = BRANCH_NE;
`endif
                    OP_J:         state_nxt = JUMP;
                    OP_ADDI:      state_nxt = ADDI_EXEC;
                    default: begin
                        state_nxt   = FETCH;
                        illegal_nxt = 1'b1;
                    end
                endcase
            end
            MEMADDR:   state_nxt = (opcode == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:   state_nxt = MEM_WB;
            EXEC_R: begin
                state_nxt   = fn_valid ? R_WB : FETCH;
                illegal_nxt = ~fn_valid;
            end
            ADDI_EXEC: state_nxt = ADDI_WB;
            default:   state_nxt = FETCH;
        endcase
    end

    // Output decode of the upcoming state; registered so every output except the branch term is Moore.
    always_comb begin
        ctrl_nxt         = CTRL_IDLE;
        ctrl_nxt.illegal = illegal_nxt;
        case (state_nxt)
            FETCH: begin
                ctrl_nxt.mem_read  = 1'b1;
                ctrl_nxt.ir_write  = 1'b1;
                ctrl_nxt.ula_src_b = SRCB_FOUR;
                ctrl_nxt.pc_write  = 1'b1;
                ctrl_nxt.pc_source = PCSRC_ULA;
            end
            DECODE:   ctrl_nxt.ula_src_b = SRCB_IMM_SH;
            MEMADDR: begin
                ctrl_nxt.ula_src_a = 1'b1;
                ctrl_nxt.ula_src_b = SRCB_IMM;
            end
            MEMREAD: begin
                ctrl_nxt.mem_read = 1'b1;
                ctrl_nxt.i_or_d   = 1'b1;
            end
            MEM_WB: begin
                ctrl_nxt.reg_write  = 1'b1;
                ctrl_nxt.mem_to_reg = 1'b1;
            end
            MEMWRITE: begin
                ctrl_nxt.mem_write = 1'b1;
                ctrl_nxt.i_or_d    = 1'b1;
            end
            EXEC_R: begin
                ctrl_nxt.ula_src_a = 1'b1;
                ctrl_nxt.ula_src_b = SRCB_REG;
                ctrl_nxt.ula_op    = fn_op;
            end
            R_WB: begin
                ctrl_nxt.reg_write = 1'b1;
                ctrl_nxt.reg_dst   = 1'b1;
            end
            BRANCH, BRANCH_NE: begin
                ctrl_nxt.ula_src_a = 1'b1;
                ctrl_nxt.ula_src_b = SRCB_REG;
                ctrl_nxt.ula_op    = ULA_SUB;
                ctrl_nxt.pc_source = PCSRC_ALUOUT;
            end
            JUMP: begin
                ctrl_nxt.pc_source = PCSRC_JUMP;
                ctrl_nxt.pc_write  = 1'b1;
            end
            ADDI_EXEC: begin
                ctrl_nxt.ula_src_a = 1'b1;
                ctrl_nxt.ula_src_b = SRCB_IMM;
            end
            ADDI_WB:  ctrl_nxt.reg_write = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RESET;
            ctrl_q  <= CTRL_IDLE;
            br_eq_q <= 1'b0;
            br_ne_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            ctrl_q  <= ctrl_nxt;
            br_eq_q <= (state_nxt == BRANCH);
            br_ne_q <= (state_nxt == BRANCH_NE);
        end
    end

    // Branch resolution uses the ULA zero flag of the same cycle.
    assign pc_write      = ctrl_q.pc_write | (br_eq_q & flagz) | (br_ne_q & ~flagz);
    assign ULAoperation  = ctrl_q.ula_op;
    assign i_or_d        = ctrl_q.i_or_d;
    assign mem_read      = ctrl_q.mem_read;
    assign mem_write     = ctrl_q.mem_write;
    assign ir_write      = ctrl_q.ir_write;
    assign reg_dst       = ctrl_q.reg_dst;
    assign mem_to_reg    = ctrl_q.mem_to_reg;
    assign reg_write     = ctrl_q.reg_write;
    assign ula_src_a     = ctrl_q.ula_src_a;
    assign ula_src_b     = ctrl_q.ula_src_b;
    assign pc_source     = ctrl_q.pc_source;
    assign illegal_instr = ctrl_q.illegal;
    assign state_dbg     = state;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Randomized self-checking bench for controle_multiciclo; honours CTRL_BNE_EN like the DUT.
module tb_controle_multiciclo;

    typedef struct packed {
        logic [3:0] ula_op;
        logic       pc_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       ula_src_a;
        logic [1:0] ula_src_b;
        logic [1:0] pc_source;
        logic       illegal;
    } exp_t;

    typedef struct {
        exp_t e;
        int   br;   // 0 none, 1 taken on zero, 2 taken on non-zero
        string name;
    } plan_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       flagz = 1'b0;
    logic [3:0] ULAoperation;
    logic       pc_write, i_or_d, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, ula_src_a, illegal_instr;
    logic [1:0] ula_src_b, pc_source;
    logic [3:0] state_dbg;

    int   n_checks = 0;
    int   n_fail = 0;
    logic pend_illegal = 1'b0;
    plan_t plan[$];

    controle_multiciclo dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .funct         (funct),
        .flagz         (flagz),
        .ULAoperation  (ULAoperation),
        .pc_write      (pc_write),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .ula_src_a     (ula_src_a),
        .ula_src_b     (ula_src_b),
        .pc_source     (pc_source),
        .illegal_instr (illegal_instr),
        .state_dbg     (state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    function automatic exp_t sample();
        return '{ULAoperation, pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst,
                 mem_to_reg, reg_write, ula_src_a, ula_src_b, pc_source, illegal_instr};
    endfunction

    // en = {pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, ula_src_a}
    function automatic exp_t mk(input logic [3:0] op, input logic [8:0] en,
                                input logic [1:0] srcb, input logic [1:0] pcs);
        exp_t e;
        e.ula_op = op;
        {e.pc_write, e.i_or_d, e.mem_read, e.mem_write, e.ir_write, e.reg_dst,
         e.mem_to_reg, e.reg_write, e.ula_src_a} = en;
        e.ula_src_b = srcb;
        e.pc_source = pcs;
        e.illegal   = 1'b0;
        return e;
    endfunction

    function automatic logic fn_known(input logic [5:0] fn);
        return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
    endfunction

    function automatic logic [3:0] ula_of(input logic [5:0] fn);
        case (fn)
            6'h22:   return 4'b0110;
            6'h24:   return 4'b0000;
            6'h25:   return 4'b0001;
            6'h27:   return 4'b1100;
            6'h2A:   return 4'b0111;
            default: return 4'b0010;
        endcase
    endfunction

    function automatic logic bne_on();
`ifdef CTRL_BNE_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Instruction cycle counts including FETCH.
    function automatic int exp_cycles(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h23:   return 5;
            6'h2B:   return 4;
            6'h08:   return 4;
            6'h04:   return 3;
            6'h02:   return 3;
            6'h05:   return bne_on() ? 3 : 2;
            6'h00:   return fn_known(fn) ? 4 : 3;
            default: return 2;
        endcase
    endfunction

    function automatic void add(input exp_t e, input int br, input string name);
        plan_t p;
        p.e = e; p.br = br; p.name = name;
        plan.push_back(p);
    endfunction

    // Expected per-cycle outputs after FETCH for one instruction.
    function automatic logic build_plan(input logic [5:0] op, input logic [5:0] fn);
        logic ill = 1'b0;
        plan.delete();
        add(mk(4'b0010, 9'b0, 2'b11, 2'b00), 0, "decode");
        case (op)
            6'h23: begin
                add(mk(4'b0010, 9'b000000001, 2'b10, 2'b00), 0, "lw_addr");
                add(mk(4'b0010, 9'b011000000, 2'b00, 2'b00), 0, "lw_read");
                add(mk(4'b0010, 9'b000000110, 2'b00, 2'b00), 0, "lw_wb");
            end
            6'h2B: begin
                add(mk(4'b0010, 9'b000000001, 2'b10, 2'b00), 0, "sw_addr");
                add(mk(4'b0010, 9'b010100000, 2'b00, 2'b00), 0, "sw_write");
            end
            6'h00: begin
                add(mk(ula_of(fn), 9'b000000001, 2'b00, 2'b00), 0, "r_exec");
                if (fn_known(fn)) add(mk(4'b0010, 9'b000001010, 2'b00, 2'b00), 0, "r_wb");
                else ill = 1'b1;
            end
            6'h04: add(mk(4'b0110, 9'b000000001, 2'b00, 2'b01), 1, "beq");
            6'h05: begin
                if (bne_on()) add(mk(4'b0110, 9'b000000001, 2'b00, 2'b01), 2, "bne");
                else ill = 1'b1;
            end
            6'h02: add(mk(4'b0010, 9'b100000000, 2'b00, 2'b10), 0, "jump");
            6'h08: begin
                add(mk(4'b0010, 9'b000000001, 2'b10, 2'b00), 0, "addi_exec");
                add(mk(4'b0010, 9'b000000010, 2'b00, 2'b00), 0, "addi_wb");
            end
            default: ill = 1'b1;
        endcase
        return ill;
    endfunction

    // Entered and left at the falling edge of a FETCH cycle.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn);
        exp_t e, obs;
        logic ill;
        int   extra, total;
        e = mk(4'b0010, 9'b101010000, 2'b01, 2'b00);
        e.illegal = pend_illegal;
        obs = sample();
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL fetch (op %h): got %h expected %h", op, obs, e);
        end
        opcode = op;
        funct  = fn;
        ill = build_plan(op, fn);
        foreach (plan[i]) begin
            @(posedge clk);
            #1 flagz = 1'($urandom);
            @(negedge clk);
            e = plan[i].e;
            if (plan[i].br == 1) e.pc_write = flagz;
            if (plan[i].br == 2) e.pc_write = ~flagz;
            obs = sample();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL %s (op %h fn %h fz %b): got %h expected %h",
                         plan[i].name, op, fn, flagz, obs, e);
            end
        end
        @(negedge clk);
        extra = 0;
        while (!(mem_read && ir_write) && extra < 8) begin
            @(negedge clk);
            extra++;
        end
        total = 1 + plan.size() + extra;
        n_checks++;
        if (total !== exp_cycles(op, fn)) begin
            n_fail++;
            $display("FAIL cycles (op %h fn %h): got %0d expected %0d", op, fn, total, exp_cycles(op, fn));
        end
        pend_illegal = ill;
    endtask

    task automatic test_reset();
        exp_t obs;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        obs = sample();
        n_checks++;
        if (obs !== mk(4'b0010, 9'b0, 2'b00, 2'b00) || state_dbg !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h state %0d expected %h state 0",
                     obs, state_dbg, mk(4'b0010, 9'b0, 2'b00, 2'b00));
        end
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({mem_read, ir_write, pc_write, ULAoperation, ula_src_b} !== {3'b111, 4'b0010, 2'b01}) begin
            n_fail++;
            $display("FAIL reset_release_fetch: got rd %b ir %b pc %b op %b srcb %b expected 1 1 1 0010 01",
                     mem_read, ir_write, pc_write, ULAoperation, ula_src_b);
        end
        pend_illegal = 1'b0;
    endtask

    task automatic test_rtype();
        logic [5:0] fns[6] = '{6'h22, 6'h2A, 6'h27, 6'h20, 6'h24, 6'h25};
        foreach (fns[i]) run_instr(6'h00, fns[i]);
    endtask

    task automatic test_branch();
        repeat (4) run_instr(6'h04, 6'($urandom));
        repeat (4) run_instr(6'h05, 6'($urandom));
        run_instr(6'h02, 6'h00);
    endtask

    task automatic test_memory();
        run_instr(6'h23, 6'h00);
        run_instr(6'h2B, 6'h00);
        run_instr(6'h08, 6'h11);
    endtask

    task automatic test_illegal();
        run_instr(6'h3F, 6'h20);
        run_instr(6'h00, 6'h3F);
        run_instr(6'h23, 6'h00);
    endtask

    task automatic test_random();
        logic [5:0] ops[8] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h08, 6'h00};
        logic [5:0] fns[6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
        logic [5:0] op, fn;
        for (int k = 0; k < 60; k++) begin
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
            fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fns[$urandom_range(0, 5)];
            run_instr(op, fn);
        end
    endtask

    task automatic test_reset_mid();
        opcode = 6'h2B;
        funct  = 6'h00;
        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (mem_write !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_setup: got mem_write %b expected 1", mem_write);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (sample() !== mk(4'b0010, 9'b0, 2'b00, 2'b00) || state_dbg !== 4'd0) begin
            n_fail++;
            $display("FAIL mid_reset_async: got %h state %0d expected %h state 0",
                     sample(), state_dbg, mk(4'b0010, 9'b0, 2'b00, 2'b00));
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if ({pc_write, ir_write, reg_write, mem_write, state_dbg} !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_reset_release: got pc %b ir %b rw %b mw %b state %0d expected all 0",
                     pc_write, ir_write, reg_write, mem_write, state_dbg);
        end
        @(posedge clk);
        @(negedge clk);
        pend_illegal = 1'b0;
        run_instr(6'h00, 6'h22);
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_branch();
        test_memory();
        test_illegal();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
